ram_bist_ctrl: RTL and testbench
================================

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 20, RAM address width; DATA_W, default 8, RAM data width; ERR_W, default 16, error counter width.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state changes on rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  start  in  1  one-cycle request to begin a run; sampled only in IDLE.
  start_addr  in  ADDR_W  first RAM address of the run.
  stride  in  8  address increment per location; 0 treated as 1.
  count  in  ADDR_W  number of locations to test.
  pattern_sel  in  1  0: data = (addr-1)[DATA_W-1:0]; 1: data = ~addr[DATA_W-1:0].
  ram_we  out  1  write enable to ram_1mb.
  ram_addr  out  ADDR_W  address to ram_1mb.
  ram_data_in  out  DATA_W  write data to ram_1mb.
  ram_data_out  in  DATA_W  read data from ram_1mb, valid one cycle after address presented with ram_we=0.
  busy  out  1  high from start acceptance until done.
  done  out  1  one-cycle pulse at end of run.
  pass  out  1  1 when the last run had zero mismatches; held until next start.
  err_count  out  ERR_W  mismatch count, saturating at all-ones.
  first_err_addr  out  ADDR_W  address of first mismatch in the last run; 0 when none.

Function
REQ-003 The FSM SHALL have states IDLE, WRITE, READ, DRAIN, DONE.
REQ-004 IDLE: on start=1, the block SHALL latch start_addr, stride, count, pattern_sel, clear err_count, first_err_addr and pass, and go to WRITE; if count=0, go directly to DONE with pass=1 and no RAM access.
REQ-005 WRITE: for count cycles the block SHALL drive ram_we=1, ram_addr = start_addr + k*stride (k = 0..count-1), and ram_data_in = the pattern for that address; it then goes to READ.
REQ-006 READ: for count cycles the block SHALL drive ram_we=0 over the same address sequence; it then goes to DRAIN.
REQ-007 Compare: one cycle after each READ address, the block SHALL compare ram_data_out with the pattern of the registered previous address.
REQ-008 On a mismatch, err_count SHALL increment (saturating), and first_err_addr SHALL capture the address only on the first mismatch of the run.
REQ-009 DRAIN SHALL last exactly one cycle and perform the final compare; DONE SHALL last one cycle with done=1, pass=(err_count==0), then return to IDLE.
REQ-010 done SHALL be high in the cycle 2*count+2 cycles after the edge that sampled start.
REQ-011 Address arithmetic SHALL be modulo 2^ADDR_W (0xFFFFF + 2 -> 0x00001).
REQ-012 start while busy SHALL be ignored, with no effect on the run in progress.
REQ-013 ram_we SHALL be 0 in every state except WRITE.
REQ-014 ram_addr and ram_data_in SHALL be registered outputs.
REQ-015 busy SHALL be 1 in WRITE, READ, DRAIN and DONE.

Reset
REQ-016 rst_n=0 SHALL asynchronously force IDLE, and drive ram_we, ram_addr, ram_data_in, busy, done, pass, err_count and first_err_addr all to 0.
REQ-017 Reset asserted mid-run SHALL abort the run with no further RAM writes; the first start after release SHALL begin a fresh run.

Structure
REQ-018 A shared package ram_bist_pkg SHALL hold ADDR_W/DATA_W defaults, the FSM state encoding and the pattern_sel codes.
REQ-019 Compare, error count and first-error capture SHALL live in one sub-module, ram_bist_checker, instantiated once.
REQ-020 The controller SHALL connect directly to ram_1mb ports clk, we, addr, data_in, data_out.

Verification
REQ-021 start_addr=1, stride=2, count=12, pattern_sel=0 -> writes data 0,2,...,22 at odd addresses 1..23; readback matches; done at cycle 26; pass=1; err_count=0.
REQ-022 Same run, with the bench forcing ram_data_out=0xFF on the read of address 7 -> err_count=1, first_err_addr=7, pass=0.
REQ-023 start_addr=0xFFFFF, stride=2, count=3 -> address sequence 0xFFFFF, 0x00001, 0x00003 for both write and read; pass=1.
REQ-024 count=0 -> done pulse with pass=1, zero cycles with ram_we=1; start pulsed mid-run -> no change to the address sequence or done timing.
REQ-025 rst_n low during WRITE at k=5 -> ram_we drops immediately; outputs are 0; a following run with count=4 completes normally with pass=1.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM BIST controller.
//   - default widths for address, data and error counter
//   - FSM state encoding
//   - pattern_sel codes and the pattern generator
package ram_bist_pkg;

    localparam int unsigned DEF_ADDR_W = 20;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ERR_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic {
        PAT_ADDR_M1  = 1'b0,   // data = addr - 1
        PAT_INV_ADDR = 1'b1    // data = ~addr
    } pat_sel_e;

    // Computed at full width; callers keep the low DATA_W bits, which
    // depend only on the low address bits for both patterns.
    function automatic logic [63:0] pattern_word(input logic [63:0] addr,
                                                 input pat_sel_e    sel);
        return (sel == PAT_INV_ADDR) ? ~addr : addr - 64'd1;
    endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Read-back checker for the RAM BIST controller.
// Registers each read address, compares the RAM data returned one cycle
// later against the expected pattern, counts mismatches (saturating) and
// captures the address of the first mismatch of the run.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr             clears counters at run start
//   rd_en           current cycle presents a read address
//   rd_addr         address presented this cycle
//   pat_sel         pattern in use for the run
//   rd_data         RAM read data (valid one cycle after the address)
//   err_count       mismatch count, saturating
//   first_err_addr  address of first mismatch, 0 when none
module ram_bist_checker
    import ram_bist_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ERR_W  = DEF_ERR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  pat_sel_e          pat_sel,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    logic              cmp_en_q;
    logic [ADDR_W-1:0] cmp_addr_q;
    logic [DATA_W-1:0] exp_data;
    logic              mismatch;

    always_comb begin
        exp_data = DATA_W'(pattern_word(64'(cmp_addr_q), pat_sel));
        mismatch = cmp_en_q && (rd_data != exp_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_en_q       <= 1'b0;
            cmp_addr_q     <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            cmp_en_q   <= rd_en;
            cmp_addr_q <= rd_addr;
            if (clr) begin
                err_count      <= '0;
                first_err_addr <= '0;
            end else if (mismatch) begin
                if (err_count != '1)
                    err_count <= err_count + ERR_W'(1);
                if (err_count == '0)
                    first_err_addr <= cmp_addr_q;
            end
        end
    end

endmodule

// File: rtl/ram_bist.sv
// RAM BIST controller: writes an address-derived pattern over a strided
// address range of ram_1mb, reads it back and reports mismatches.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      run request, sampled in IDLE only
//   start_addr, stride, count  address range of the run (stride 0 = 1)
//   pattern_sel                0: addr-1, 1: ~addr
//   ram_we, ram_addr,
//   ram_data_in, ram_data_out  direct connection to ram_1mb
//   busy, done, pass           run status
//   err_count, first_err_addr  mismatch results of the last run
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ERR_W  = DEF_ERR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        stride,
    input  logic [ADDR_W-1:0] count,
    input  logic              pattern_sel,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic              we_d;
    logic [ADDR_W-1:0] rem_q, rem_d;     // locations left after the current one
    logic [ADDR_W-1:0] base_q, stride_q, count_q;
    pat_sel_e          pat_q;
    logic              pass_q;
    logic              accept;
    logic [ADDR_W-1:0] step_addr;

    assign accept    = (state_q == ST_IDLE) && start;
    assign step_addr = ram_addr + stride_q;

    always_comb begin
        state_d = state_q;
        addr_d  = ram_addr;
        data_d  = ram_data_in;
        we_d    = 1'b0;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                        addr_d  = start_addr;
                        data_d  = DATA_W'(pattern_word(64'(start_addr), pat_sel_e'(pattern_sel)));
                        we_d    = 1'b1;
                        rem_d   = count - ADDR_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                if (rem_q == '0) begin
                    state_d = ST_READ;
                    addr_d  = base_q;
                    rem_d   = count_q - ADDR_W'(1);
                end else begin
                    addr_d = step_addr;
                    data_d = DATA_W'(pattern_word(64'(step_addr), pat_q));
                    we_d   = 1'b1;
                    rem_d  = rem_q - ADDR_W'(1);
                end
            end
            ST_READ: begin
                if (rem_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = step_addr;
                    rem_d  = rem_q - ADDR_W'(1);
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            rem_q       <= '0;
            base_q      <= '0;
            stride_q    <= '0;
            count_q     <= '0;
            pat_q       <= PAT_ADDR_M1;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_we      <= we_d;
            ram_addr    <= addr_d;
            ram_data_in <= data_d;
            rem_q       <= rem_d;
            if (accept) begin
                base_q   <= start_addr;
                stride_q <= (stride == 8'd0) ? ADDR_W'(1) : ADDR_W'(stride);
                count_q  <= count;
                pat_q    <= pat_sel_e'(pattern_sel);
                pass_q   <= 1'b0;
            end else if (state_q == ST_DONE) begin
                pass_q <= (err_count == '0);
            end
        end
    end

    // The final compare lands on the edge entering DONE, so pass is taken
    // live from the counter during DONE and held from pass_q afterwards.
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign pass = done ? (err_count == '0) : pass_q;

    ram_bist_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ERR_W  (ERR_W)
    ) u_checker (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (accept),
        .rd_en          (state_q == ST_READ),
        .rd_addr        (ram_addr),
        .pat_sel        (pat_q),
        .rd_data        (ram_data_out),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
module tb_ram_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [19:0] start_addr;
    logic [7:0]  stride;
    logic [19:0] count;
    logic        pattern_sel;
    logic        ram_we;
    logic [19:0] ram_addr;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [19:0] first_err_addr;

    ram_bist_ctrl #(.ADDR_W(20), .DATA_W(8), .ERR_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .start_addr     (start_addr),
        .stride         (stride),
        .count          (count),
        .pattern_sel    (pattern_sel),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_data_in    (ram_data_in),
        .ram_data_out   (ram_data_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ram_1mb with an optional stuck-at-0xFF read fault.
    logic [7:0]  mem [0:(1<<20)-1];
    bit          fault_en = 1'b0;
    logic [19:0] fault_addr = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data_in;
        ram_data_out <= (fault_en && ram_addr == fault_addr) ? 8'hFF : mem[ram_addr];
    end

    typedef struct { int unsigned cyc; logic [19:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int unsigned cyc; logic [19:0] addr; } rd_t;
    typedef struct { int unsigned cyc; logic pass; logic [15:0] err; logic [19:0] first; } done_t;

    wr_t   wr_q[$];
    rd_t   rd_q[$];
    done_t done_q[$];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected write/read traffic and result of one run.
    task automatic plan(input logic [19:0] sa, input logic [7:0] st, input int unsigned cnt,
                        input logic sel, input bit fen, input logic [19:0] fa,
                        input int unsigned t0, input int unsigned wr_limit, input bit full,
                        output done_t d);
        int unsigned steff;
        int unsigned err;
        logic [19:0] first;
        logic [19:0] a;
        logic [7:0]  dat;
        steff = (st == 8'd0) ? 1 : 32'(st);
        err   = 0;
        first = '0;
        for (int unsigned k = 0; k < cnt; k++) begin
            a   = 20'(32'(sa) + k * steff);
            dat = sel ? ~a[7:0] : 8'(a - 20'd1);
            if (k < wr_limit) wr_q.push_back('{t0 + 1 + k, a, dat});
            if (full)         rd_q.push_back('{t0 + 1 + cnt + k, a});
            if (fen && a == fa && dat != 8'hFF) begin
                if (err == 0) first = a;
                err++;
            end
        end
        d = '{(cnt == 0) ? t0 + 1 : t0 + 2 * cnt + 2, (err == 0), 16'(err), first};
        if (full) done_q.push_back(d);
    endtask

    // Monitor: pops expectations whenever the DUT presents traffic.
    initial begin
        wr_t   w;
        rd_t   r;
        done_t d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ram_we) begin
                    if (wr_q.size() == 0) begin
                        chk("unexpected_write", 64'(ram_we), 64'(0));
                    end else begin
                        w = wr_q.pop_front();
                        chk("wr_cycle", 64'(cyc), 64'(w.cyc));
                        chk("wr_addr", 64'(ram_addr), 64'(w.addr));
                        chk("wr_data", 64'(ram_data_in), 64'(w.data));
                    end
                end
                if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
                    r = rd_q.pop_front();
                    chk("rd_we", 64'(ram_we), 64'(0));
                    chk("rd_addr", 64'(ram_addr), 64'(r.addr));
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 64'(done), 64'(0));
                    end else begin
                        d = done_q.pop_front();
                        chk("done_cycle", 64'(cyc), 64'(d.cyc));
                        chk("done_pass", 64'(pass), 64'(d.pass));
                        chk("done_err_count", 64'(err_count), 64'(d.err));
                        chk("done_first_err", 64'(first_err_addr), 64'(d.first));
                        chk("done_busy", 64'(busy), 64'(1));
                    end
                end
            end
        end
    end

    task automatic do_run(input logic [19:0] sa, input logic [7:0] st, input int unsigned cnt,
                          input logic sel, input bit fen, input logic [19:0] fa, input bit mid_start);
        done_t       d;
        int unsigned t0;
        int unsigned deadline;
        @(negedge clk);
        fault_en    = fen;
        fault_addr  = fa;
        start_addr  = sa;
        stride      = st;
        count       = 20'(cnt);
        pattern_sel = sel;
        start       = 1'b1;
        t0          = cyc;
        plan(sa, st, cnt, sel, fen, fa, t0, cnt, 1'b1, d);
        @(posedge clk);
        #1 start = 1'b0;
        deadline = t0 + 2 * cnt + 12;
        while (done_q.size() != 0 && cyc < deadline) begin
            @(negedge clk);
            if (mid_start && cyc <= t0 + 2 * cnt + 2) begin
                start       = ($urandom_range(0, 2) == 0);
                start_addr  = 20'($urandom);
                stride      = 8'($urandom);
                count       = 20'($urandom_range(1, 40));
                pattern_sel = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", 64'(done_q.size()), 64'(0));
        chk("reads_pending", 64'(rd_q.size()), 64'(0));
        chk("writes_pending", 64'(wr_q.size()), 64'(0));
        wr_q.delete();
        rd_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        chk("pass_held", 64'(pass), 64'(d.pass));
        chk("idle_busy", 64'(busy), 64'(0));
        fault_en = 1'b0;
    endtask

    initial begin
        done_t       d;
        int unsigned t0;
        rst_n       = 1'b0;
        start       = 1'b0;
        start_addr  = '0;
        stride      = '0;
        count       = '0;
        pattern_sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we", 64'(ram_we), 64'(0));
        chk("rst_addr", 64'(ram_addr), 64'(0));
        chk("rst_data", 64'(ram_data_in), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_pass", 64'(pass), 64'(0));
        chk("rst_err", 64'(err_count), 64'(0));
        chk("rst_first", 64'(first_err_addr), 64'(0));
        rst_n = 1'b1;

        // Odd addresses 1..23, data 0..22, clean and with a fault at 7.
        do_run(20'd1, 8'd2, 12, 1'b0, 1'b0, 20'd0, 1'b0);
        do_run(20'd1, 8'd2, 12, 1'b0, 1'b1, 20'd7, 1'b0);
        // Wrap across the top of the address space.
        do_run(20'hFFFFF, 8'd2, 3, 1'b0, 1'b0, 20'd0, 1'b0);
        do_run(20'hFFFFF, 8'd2, 3, 1'b1, 1'b0, 20'd0, 1'b0);
        // Empty run, stride 0, and start/config noise while busy.
        do_run(20'h12345, 8'd5, 0, 1'b1, 1'b0, 20'd0, 1'b0);
        do_run(20'h00100, 8'd0, 6, 1'b1, 1'b1, 20'h00103, 1'b0);
        do_run(20'h00040, 8'd3, 9, 1'b0, 1'b0, 20'd0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            logic [19:0] sa;
            logic [7:0]  st;
            int unsigned cnt;
            int unsigned steff;
            bit          fen;
            logic [19:0] fa;
            sa    = (i % 3 == 0) ? 20'(20'hFFFFF - 20'($urandom_range(0, 40))) : 20'($urandom);
            st    = 8'($urandom);
            cnt   = $urandom_range(0, 16);
            steff = (st == 8'd0) ? 1 : 32'(st);
            fen   = (cnt != 0) && ($urandom_range(0, 1) == 1);
            fa    = (cnt != 0) ? 20'(32'(sa) + $urandom_range(0, cnt - 1) * steff) : 20'd0;
            do_run(sa, st, cnt, 1'($urandom), fen, fa, (i % 2) == 1);
        end

        // Reset during write k=5: no further writes, all outputs cleared.
        @(negedge clk);
        start_addr  = 20'h00200;
        stride      = 8'd1;
        count       = 20'd10;
        pattern_sel = 1'b0;
        start       = 1'b1;
        t0          = cyc;
        plan(20'h00200, 8'd1, 10, 1'b0, 1'b0, 20'd0, t0, 5, 1'b0, d);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_we", 64'(ram_we), 64'(0));
        chk("abort_addr", 64'(ram_addr), 64'(0));
        chk("abort_data", 64'(ram_data_in), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_pass", 64'(pass), 64'(0));
        chk("abort_err", 64'(err_count), 64'(0));
        chk("abort_first", 64'(first_err_addr), 64'(0));
        chk("abort_writes_done", 64'(wr_q.size()), 64'(0));
        wr_q.delete();
        repeat (3) @(negedge clk);
        chk("abort_held_we", 64'(ram_we), 64'(0));
        rst_n = 1'b1;
        do_run(20'h00300, 8'd4, 4, 1'b1, 1'b0, 20'd0, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
